// File: rtl/riscv_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_boot_ctrl
// Purpose  : Boot/run controller for a RISC-V core. It streams program words
//            into instruction memory, holds the core in reset for a fixed
//            number of cycles, then releases it. While the core runs, the
//            controller watches the PC and reports completion on either a
//            self-loop halt or an exhausted cycle budget. A restart from DONE
//            reruns the already-loaded program.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            i_load_valid/_data/_last, o_load_ready - program word stream
//            i_restart          - rerun request (honoured only in DONE)
//            o_imem_we/_addr/_wdata - instruction memory write port
//            o_core_rst         - core reset, active-high
//            i_core_pc          - core program counter
//            o_run_cycles       - RUN cycles since last release (saturating)
//            o_done, o_status   - sticky completion flag and reason code
// Revision : 1.0 - initial release
// ============================================================================
module riscv_boot_ctrl #(
  parameter int XLEN        = 32,
  parameter int IMEM_DEPTH  = 256,
  parameter int ADDR_W      = 8,
  parameter int RST_HOLD    = 2,
  parameter int MAX_CYCLES  = 100,
  parameter int STALL_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_valid,
  input  logic [XLEN-1:0]   i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  input  logic              i_restart,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [XLEN-1:0]   o_imem_wdata,
  output logic              o_core_rst,
  input  logic [XLEN-1:0]   i_core_pc,
  output logic [31:0]       o_run_cycles,
  output logic              o_done,
  output logic [1:0]        o_status
);

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_HOLD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE   = ADDR_W'(1);
  localparam logic [31:0]       c_HOLD_LAST  = 32'(RST_HOLD - 1);
  localparam logic [31:0]       c_MAX_CYCLES = 32'(MAX_CYCLES);
  localparam logic [31:0]       c_STALL_LIM  = 32'(STALL_LIMIT);

  localparam logic [1:0] c_ST_NONE    = 2'b00;
  localparam logic [1:0] c_ST_HALT    = 2'b01;
  localparam logic [1:0] c_ST_TIMEOUT = 2'b10;
  localparam logic [1:0] c_ST_OVFL    = 2'b11;

  state_t              r_state;
  logic                r_load_ready;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [XLEN-1:0]     r_imem_wdata;
  logic                r_core_rst;
  logic [31:0]         r_run_cycles;
  logic                r_done;
  logic [1:0]          r_status;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [31:0]         r_hold_cnt;
  logic [31:0]         r_stall_cnt;
  logic [XLEN-1:0]     r_pc_q;
  logic                r_pc_valid;

  logic [31:0]         w_run_inc;
  logic [31:0]         w_stall_nxt;
  logic                w_handshake;

  assign w_handshake = i_load_valid & r_load_ready;

  // Saturating increment; MAX_CYCLES normally stops the run long before.
  assign w_run_inc = (r_run_cycles == 32'hFFFF_FFFF) ? r_run_cycles
                                                      : r_run_cycles + 32'd1;

  // The first RUN cycle only primes pc_q, so no stall can be counted there.
  assign w_stall_nxt = (r_pc_valid && (i_core_pc == r_pc_q)) ? r_stall_cnt + 32'd1
                                                             : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LOAD;
      r_load_ready <= 1'b1;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_core_rst   <= 1'b1;
      r_run_cycles <= 32'd0;
      r_done       <= 1'b0;
      r_status     <= c_ST_NONE;
      r_wr_ptr     <= '0;
      r_hold_cnt   <= 32'd0;
      r_stall_cnt  <= 32'd0;
      r_pc_q       <= '0;
      r_pc_valid   <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_handshake) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_wr_ptr;
            r_imem_wdata <= i_load_data;
            r_wr_ptr     <= r_wr_ptr + c_ADDR_ONE;
            // A last word in the final slot is a valid full program.
            if (i_load_last) begin
              r_state      <= S_HOLD;
              r_load_ready <= 1'b0;
              r_hold_cnt   <= 32'd0;
            end else if (r_wr_ptr == c_LAST_ADDR) begin
              r_state      <= S_ERR;
              r_load_ready <= 1'b0;
              r_done       <= 1'b1;
              r_status     <= c_ST_OVFL;
            end
          end
        end

        S_HOLD: begin
          if (r_hold_cnt == c_HOLD_LAST) begin
            r_state    <= S_RUN;
            r_core_rst <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
          end
        end

        S_RUN: begin
          r_run_cycles <= w_run_inc;
          r_pc_q       <= i_core_pc;
          r_pc_valid   <= 1'b1;
          r_stall_cnt  <= w_stall_nxt;
          // Halt is tested first so it wins a same-cycle timeout.
          if (w_stall_nxt == c_STALL_LIM) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_status <= c_ST_HALT;
          end else if (w_run_inc >= c_MAX_CYCLES) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_status <= c_ST_TIMEOUT;
          end
        end

        S_DONE: begin
          // Core keeps running (core_rst low) until a restart; imem untouched.
          if (i_restart) begin
            r_state      <= S_HOLD;
            r_done       <= 1'b0;
            r_status     <= c_ST_NONE;
            r_run_cycles <= 32'd0;
            r_stall_cnt  <= 32'd0;
            r_pc_valid   <= 1'b0;
            r_core_rst   <= 1'b1;
            r_hold_cnt   <= 32'd0;
          end
        end

        S_ERR: begin
          // Terminal until rst.
        end

        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign o_load_ready = r_load_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_core_rst   = r_core_rst;
  assign o_run_cycles = r_run_cycles;
  assign o_done       = r_done;
  assign o_status     = r_status;

endmodule
`default_nettype wire

// File: tb/tb_riscv_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_boot_ctrl
// Purpose  : Scoreboard bench for riscv_boot_ctrl. Stimulus pushes expected
//            writes, reset-release lengths and completion results into
//            queues; a monitor pops and compares as the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_boot_ctrl;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        restart;
  logic        imem_we;
  logic [2:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic [31:0] core_pc;
  logic [31:0] run_cycles;
  logic        done;
  logic [1:0]  status;

  riscv_boot_ctrl #(
    .XLEN(32), .IMEM_DEPTH(8), .ADDR_W(3),
    .RST_HOLD(2), .MAX_CYCLES(100), .STALL_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_load_valid(load_valid), .i_load_data(load_data), .i_load_last(load_last),
    .o_load_ready(load_ready), .i_restart(restart),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
    .o_core_rst(core_rst), .i_core_pc(core_pc), .o_run_cycles(run_cycles),
    .o_done(done), .o_status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [2:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [1:0] st; logic [31:0] rc; } dn_t;
  wr_t q_wr[$];
  int  q_rel[$];
  dn_t q_done[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // ---------------- monitor ----------------
  logic prev_core_rst = 1'b1;
  logic prev_done     = 1'b0;
  int   m_hold        = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      if (q_wr.size() == 0) fail_now("unexpected_imem_write");
      else begin
        wr_t e;
        e = q_wr.pop_front();
        chk("imem_addr", 64'(imem_addr), 64'(e.addr));
        chk("imem_wdata", 64'(imem_wdata), 64'(e.data));
      end
    end
    if (prev_core_rst && !core_rst) begin
      if (q_rel.size() == 0) fail_now("unexpected_release");
      else chk("hold_cycles", 64'(m_hold), 64'(q_rel.pop_front()));
    end
    if (core_rst && !load_ready && !done) m_hold++;
    else m_hold = 0;
    if (done && !prev_done) begin
      if (q_done.size() == 0) fail_now("unexpected_done");
      else begin
        dn_t d;
        d = q_done.pop_front();
        chk("done_status", 64'(status), 64'(d.st));
        chk("done_run_cycles", 64'(run_cycles), 64'(d.rc));
      end
    end
    prev_core_rst = core_rst;
    prev_done     = done;
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic check_reset(input string tag);
    chk({tag, "_load_ready"}, 64'(load_ready), 64'd1);
    chk({tag, "_imem_we"},    64'(imem_we),    64'd0);
    chk({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_core_rst"},   64'(core_rst),   64'd1);
    chk({tag, "_run_cycles"}, 64'(run_cycles), 64'd0);
    chk({tag, "_done"},       64'(done),       64'd0);
    chk({tag, "_status"},     64'(status),     64'd0);
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] a);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    while (!load_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!load_ready) fail_now("load_ready_timeout");
    else q_wr.push_back({a, d});
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    while (core_rst && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (core_rst) fail_now("release_timeout");
  endtask

  function automatic logic [31:0] pcf(input int mode, input int i);
    case (mode)
      0:       return (i < 3) ? 32'(4 * i) : 32'd12;
      1:       return 32'(4 * i);
      default: return (i < 95) ? 32'(4 * i) : 32'd380;
    endcase
  endfunction

  task automatic run_prog(input int mode);
    wait_release();
    for (int i = 0; i < 200 && !done; i++) begin
      core_pc = pcf(mode, i);
      @(negedge clk);
    end
    if (!done) fail_now("done_timeout");
  endtask

  task automatic do_restart();
    q_rel.push_back(2);
    restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0;
    chk("rs_done",       64'(done),       64'd0);
    chk("rs_status",     64'(status),     64'd0);
    chk("rs_run_cycles", 64'(run_cycles), 64'd0);
    chk("rs_core_rst",   64'(core_rst),   64'd1);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h00500093;
    prog[1] = 32'h00108113;
    prog[2] = 32'h002081B3;
    prog[3] = 32'h0000006F;
    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    restart = 1'b0; core_pc = '0;
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);

    // restart must be ignored outside DONE
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("ign_restart_ready", 64'(load_ready), 64'd1);
    chk("ign_restart_done",  64'(done),       64'd0);

    // load + self-loop halt
    q_rel.push_back(2);
    q_done.push_back({2'b01, 32'd8});
    for (int i = 0; i < 4; i++) send(prog[i], (i == 3), 3'(i));
    run_prog(0);
    repeat (3) @(negedge clk);
    chk("done_frozen_run", 64'(run_cycles), 64'd8);
    chk("done_core_rst",   64'(core_rst),   64'd0);
    chk("done_sticky",     64'(done),       64'd1);

    // restart -> timeout
    do_restart();
    q_done.push_back({2'b10, 32'd100});
    run_prog(1);

    // restart -> halt and timeout coincide
    do_restart();
    q_done.push_back({2'b01, 32'd100});
    run_prog(2);

    // restart, then asynchronous reset mid-RUN
    do_restart();
    wait_release();
    for (int i = 0; i < 5; i++) begin
      core_pc = 32'(4 * i);
      @(negedge clk);
    end
    chk("midrun_run_cycles", 64'(run_cycles), 64'd5);
    #2 rst = 1'b1;
    #1 check_reset("async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // overflow of an 8-deep memory
    q_done.push_back({2'b11, 32'd0});
    for (int i = 0; i < 8; i++) send(32'hA000_0000 + 32'(i), 1'b0, 3'(i));
    chk("err_status",     64'(status),     64'd3);
    chk("err_done",       64'(done),       64'd1);
    chk("err_core_rst",   64'(core_rst),   64'd1);
    chk("err_load_ready", 64'(load_ready), 64'd0);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    load_valid = 1'b0;
    chk("err_still_ready", 64'(load_ready), 64'd0);
    chk("err_still_stat",  64'(status),     64'd3);

    repeat (2) @(negedge clk);
    chk("q_wr_empty",   64'(q_wr.size()),   64'd0);
    chk("q_rel_empty",  64'(q_rel.size()),  64'd0);
    chk("q_done_empty", 64'(q_done.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
